uart_tx_cfg: RTL and testbench
==============================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, line rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, payload width; legal 5..9.
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal 1 or 2.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-008 SHALL have port send, input, 1, transmit request; sampled only in IDLE.
REQ-009 SHALL have port data, input, DATA_BITS, payload; captured when a request is accepted.
REQ-010 SHALL have port tx, output, 1, serial line; idle level 1.
REQ-011 SHALL have port busy, output, 1, high from request acceptance until the frame ends.
REQ-012 SHALL have port tx_done, output, 1, one-cycle frame-complete pulse.

Function
REQ-013 SHALL derive CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division); elaboration SHALL fail if CLKS_PER_BIT < 2 or any parameter is outside its legal range.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE: tx=1, busy=0; send=1 at an edge -> START at that edge, data latched into a shift register at the same edge.
REQ-016 Data changes after acceptance SHALL NOT affect the frame in flight.
REQ-017 START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA.
REQ-018 DATA: bits sent LSB first, each held exactly CLKS_PER_BIT cycles; after bit DATA_BITS-1 -> PARITY if PARITY!=0, else STOP.
REQ-019 PARITY: tx = XOR of the latched payload (even) or its inverse (odd), held CLKS_PER_BIT cycles, then STOP.
REQ-020 STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
REQ-021 tx_done SHALL be 1 for exactly the first cycle back in IDLE after a complete frame, and 0 otherwise.
REQ-022 Frame length SHALL be (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles from the accepting edge to the return to IDLE.
REQ-023 send while busy=1 SHALL be ignored; requests are neither queued nor counted.
REQ-024 send=1 in the tx_done cycle SHALL be accepted, giving back-to-back frames with no extra idle gap.
REQ-025 tx, busy and tx_done SHALL be driven directly from flops; no combinational path from send or data to any output.
REQ-026 The baud counter SHALL restart at 0 on every state change; the bit index SHALL count 0..DATA_BITS-1 with no wrap-around.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, tx=1, busy=0, tx_done=0, counters 0, regardless of state.
REQ-028 Reset mid-frame SHALL abort the frame without a tx_done pulse; rst and send asserted together SHALL give reset priority, and the request SHALL be dropped.
REQ-029 The first edge with rst=0 and send=1 SHALL start a frame normally.

Structure
REQ-030 Package uart_pkg SHALL hold the state enum and the named parity-mode constants (PARITY_NONE, PARITY_ODD, PARITY_EVEN).
REQ-031 Baud timing SHALL be in sub-module uart_baud_gen (parameter CLKS_PER_BIT; inputs clk, rst, clear; output tick asserted on the last cycle of each bit period).

Verification
REQ-032 All scenarios SHALL use CLK_FREQ=50_000_000 and BAUD_RATE=25_000_000, giving 2 cycles/bit.
REQ-033 8N1, data=8'h55: tx=0 for 2 cycles, then 1,0,1,0,1,0,1,0 with 2 cycles each, then 1 for 2 cycles; tx_done pulses on cycle 21 after acceptance; data changed to 8'hFF mid-frame has no effect.
REQ-034 Reset during data bit 3: the next cycle is IDLE with tx=1 and busy=0, and tx_done never pulses; a following send of 8'hA5 gives a correct frame.
REQ-035 PARITY=2 (even), data=8'h07: parity bit=1; with PARITY=1 (odd) it is 0; frame length 22 cycles.
REQ-036 DATA_BITS=5, STOP_BITS=2, data=5'b10011: bits 1,1,0,0,1, then 4 cycles of stop, tx_done on cycle 17.
REQ-037 send held high continuously with 8'h01 then 8'h80: two contiguous frames, one tx_done per frame, no idle gap; a send pulse mid-frame is ignored.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Request/status bundle between a frame producer and uart_tx_cfg.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
) ();

  // Handshake: send acts as valid and ~busy as ready. A request is taken on
  // the rising edge where send=1 and the transmitter is idle; requests made
  // while busy=1 are dropped, never queued. data is captured on that edge.
  logic                 send;
  logic [DATA_BITS-1:0] data;
  logic                 tx;
  logic                 busy;
  logic                 tx_done;

  modport master (
    output send,
    output data,
    input  tx,
    input  busy,
    input  tx_done
  );

  modport slave (
    input  send,
    input  data,
    output tx,
    output busy,
    output tx_done
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: tick marks the last clock of each bit period.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CW'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, 5..9 data bits LSB first,
// optional odd/even parity, 1 or 2 stop bits.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_cfg_if.slave  bus,
  output uart_state_t   dbg_state
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int IDX_W        = $clog2(DATA_BITS);

  if (CLKS_PER_BIT < 2) begin : g_bad_rate
    $error("uart_tx_cfg: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  uart_state_t          state;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic                 tick;
  logic                 clear;

  // Every non-idle state change happens on a tick, so clearing on tick and
  // holding in IDLE restarts the bit timer at 0 on each state change.
  assign clear = (state == ST_IDLE) || tick;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      bus.tx      <= 1'b1;
      bus.busy    <= 1'b0;
      bus.tx_done <= 1'b0;
      shift       <= '0;
      par_bit     <= 1'b0;
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
    end else begin
      bus.tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          bus.tx   <= 1'b1;
          bus.busy <= 1'b0;
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          if (bus.send) begin
            state    <= ST_START;
            bus.tx   <= 1'b0;
            bus.busy <= 1'b1;
            shift    <= bus.data;
            par_bit  <= (PARITY == PARITY_EVEN) ? ^bus.data : ~(^bus.data);
          end
        end
        ST_START: begin
          if (tick) begin
            state  <= ST_DATA;
            bus.tx <= shift[0];
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
              if (PARITY != PARITY_NONE) begin
                state  <= ST_PARITY;
                bus.tx <= par_bit;
              end else begin
                state  <= ST_STOP;
                bus.tx <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= shift >> 1;
              bus.tx  <= shift[1];
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state  <= ST_STOP;
            bus.tx <= 1'b1;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (stop_idx == 1'(STOP_BITS - 1)) begin
              state       <= ST_IDLE;
              bus.busy    <= 1'b0;
              bus.tx_done <= 1'b1;
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          bus.tx   <= 1'b1;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg at 2 clocks/bit across four configurations.
module tb_uart_tx_cfg;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   sel;
  logic send_v;
  logic [8:0] data_v;
  int   checks = 0;
  int   failures = 0;

  logic        obs_tx, obs_busy, obs_done;
  uart_state_t obs_state;
  uart_state_t st_8n1, st_8e1, st_8o1, st_5n2;

  uart_tx_cfg_if #(.DATA_BITS(8)) if_8n1 ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if_8e1 ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if_8o1 ();
  uart_tx_cfg_if #(.DATA_BITS(5)) if_5n2 ();

  assign if_8n1.send = (sel == 0) && send_v;
  assign if_8e1.send = (sel == 1) && send_v;
  assign if_8o1.send = (sel == 2) && send_v;
  assign if_5n2.send = (sel == 3) && send_v;
  assign if_8n1.data = data_v[7:0];
  assign if_8e1.data = data_v[7:0];
  assign if_8o1.data = data_v[7:0];
  assign if_5n2.data = data_v[4:0];

  uart_tx_cfg #(.CLK_FREQ(50_000_000), .BAUD_RATE(25_000_000), .DATA_BITS(8),
                .PARITY(0), .STOP_BITS(1))
    dut_8n1 (.clk(clk), .rst(rst), .bus(if_8n1), .dbg_state(st_8n1));
  uart_tx_cfg #(.CLK_FREQ(50_000_000), .BAUD_RATE(25_000_000), .DATA_BITS(8),
                .PARITY(2), .STOP_BITS(1))
    dut_8e1 (.clk(clk), .rst(rst), .bus(if_8e1), .dbg_state(st_8e1));
  uart_tx_cfg #(.CLK_FREQ(50_000_000), .BAUD_RATE(25_000_000), .DATA_BITS(8),
                .PARITY(1), .STOP_BITS(1))
    dut_8o1 (.clk(clk), .rst(rst), .bus(if_8o1), .dbg_state(st_8o1));
  uart_tx_cfg #(.CLK_FREQ(50_000_000), .BAUD_RATE(25_000_000), .DATA_BITS(5),
                .PARITY(0), .STOP_BITS(2))
    dut_5n2 (.clk(clk), .rst(rst), .bus(if_5n2), .dbg_state(st_5n2));

  always #5 clk = ~clk;

  always_comb begin
    obs_tx    = if_8n1.tx;
    obs_busy  = if_8n1.busy;
    obs_done  = if_8n1.tx_done;
    obs_state = st_8n1;
    case (sel)
      1: begin obs_tx = if_8e1.tx; obs_busy = if_8e1.busy; obs_done = if_8e1.tx_done; obs_state = st_8e1; end
      2: begin obs_tx = if_8o1.tx; obs_busy = if_8o1.busy; obs_done = if_8o1.tx_done; obs_state = st_8o1; end
      3: begin obs_tx = if_5n2.tx; obs_busy = if_5n2.busy; obs_done = if_5n2.tx_done; obs_state = st_5n2; end
      default: ;
    endcase
  end

  task automatic test_reset;
    rst = 1'b1; send_v = 1'b0; data_v = '0; sel = 0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      checks++;
      if (obs_tx !== 1'b1 || obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_state !== ST_IDLE) begin
        failures++;
        $display("FAIL reset dut%0d: tx=%b busy=%b done=%b state=%0d, required tx=1 busy=0 done=0 state=0",
                 s, obs_tx, obs_busy, obs_done, obs_state);
      end
    end
    sel = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // 8N1 0x55, payload changed to 0xFF mid-frame; tx_done on cycle 21.
  task automatic test_8n1;
    logic [0:0] exp_q[$];
    int n;
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    n = exp_q.size() * 2;
    sel = 0;
    @(negedge clk); send_v = 1'b1; data_v = 9'h055;
    for (int c = 1; c <= n + 2; c++) begin
      @(negedge clk);
      if (c == 1) send_v = 1'b0;
      if (c == 5) data_v = 9'h0FF;
      checks++;
      if (c <= n) begin
        if (obs_tx !== exp_q[(c-1)/2] || obs_busy !== 1'b1 || obs_done !== 1'b0) begin
          failures++;
          $display("FAIL 8n1 cycle %0d: tx=%b busy=%b done=%b, required tx=%b busy=1 done=0",
                   c, obs_tx, obs_busy, obs_done, exp_q[(c-1)/2]);
        end
      end else if (obs_tx !== 1'b1 || obs_busy !== 1'b0 || obs_done !== (c == n + 1)) begin
        failures++;
        $display("FAIL 8n1 end cycle %0d: tx=%b busy=%b done=%b, required tx=1 busy=0 done=%b",
                 c, obs_tx, obs_busy, obs_done, (c == n + 1));
      end
    end
  endtask

  // Reset in data bit 3 of 0x5A, then a clean 0xA5 frame.
  task automatic test_reset_mid_frame;
    logic [0:0] exp_q[$];
    int n;
    int pulses;
    sel = 0;
    @(negedge clk); send_v = 1'b1; data_v = 9'h05A;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) send_v = 1'b0;
    end
    checks++;
    if (obs_tx !== 1'b1 || obs_state !== ST_DATA) begin
      failures++;
      $display("FAIL midrst bit3: tx=%b state=%0d, required tx=1 state=%0d", obs_tx, obs_state, ST_DATA);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (obs_tx !== 1'b1 || obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_state !== ST_IDLE) begin
      failures++;
      $display("FAIL midrst after: tx=%b busy=%b done=%b state=%0d, required 1 0 0 0",
               obs_tx, obs_busy, obs_done, obs_state);
    end
    pulses = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (obs_done === 1'b1 || obs_busy !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL midrst quiet: activity cycles=%0d, required 0", pulses);
    end
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    n = exp_q.size() * 2;
    send_v = 1'b1; data_v = 9'h0A5;
    for (int c = 1; c <= n + 1; c++) begin
      @(negedge clk);
      if (c == 1) send_v = 1'b0;
      checks++;
      if (c <= n) begin
        if (obs_tx !== exp_q[(c-1)/2] || obs_busy !== 1'b1 || obs_done !== 1'b0) begin
          failures++;
          $display("FAIL a5 cycle %0d: tx=%b busy=%b done=%b, required tx=%b busy=1 done=0",
                   c, obs_tx, obs_busy, obs_done, exp_q[(c-1)/2]);
        end
      end else if (obs_tx !== 1'b1 || obs_busy !== 1'b0 || obs_done !== 1'b1) begin
        failures++;
        $display("FAIL a5 done: tx=%b busy=%b done=%b, required 1 0 1", obs_tx, obs_busy, obs_done);
      end
    end
  endtask

  // rst and send together: request dropped; first edge with rst=0 starts.
  task automatic test_reset_priority;
    int pulses;
    sel = 0;
    @(negedge clk); rst = 1'b1; send_v = 1'b1; data_v = 9'h033;
    @(negedge clk);
    checks++;
    if (obs_busy !== 1'b0 || obs_state !== ST_IDLE) begin
      failures++;
      $display("FAIL rstprio held: busy=%b state=%0d, required busy=0 state=0", obs_busy, obs_state);
    end
    rst = 1'b0;
    @(negedge clk);
    send_v = 1'b0;
    checks++;
    if (obs_busy !== 1'b1 || obs_tx !== 1'b0 || obs_state !== ST_START) begin
      failures++;
      $display("FAIL rstprio start: busy=%b tx=%b state=%0d, required busy=1 tx=0 state=%0d",
               obs_busy, obs_tx, obs_state, ST_START);
    end
    pulses = 0;
    for (int c = 2; c <= 24; c++) begin
      @(negedge clk);
      if (obs_done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL rstprio done: pulses=%0d, required 1", pulses);
    end
  endtask

  // 0x07 with even (sel 1, parity 1) and odd (sel 2, parity 0); 22 cycles.
  task automatic test_parity;
    logic [0:0] exp_q[$];
    logic p;
    int n;
    for (int s = 1; s <= 2; s++) begin
      p = (s == 1);
      exp_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, p, 1'b1};
      n = exp_q.size() * 2;
      sel = s;
      @(negedge clk); send_v = 1'b1; data_v = 9'h007;
      for (int c = 1; c <= n + 1; c++) begin
        @(negedge clk);
        if (c == 1) send_v = 1'b0;
        checks++;
        if (c <= n) begin
          if (obs_tx !== exp_q[(c-1)/2] || obs_busy !== 1'b1 || obs_done !== 1'b0) begin
            failures++;
            $display("FAIL parity dut%0d cycle %0d: tx=%b busy=%b done=%b, required tx=%b busy=1 done=0",
                     s, c, obs_tx, obs_busy, obs_done, exp_q[(c-1)/2]);
          end
        end else if (obs_tx !== 1'b1 || obs_busy !== 1'b0 || obs_done !== 1'b1) begin
          failures++;
          $display("FAIL parity dut%0d done: tx=%b busy=%b done=%b, required 1 0 1",
                   s, obs_tx, obs_busy, obs_done);
        end
      end
    end
  endtask

  // 5 data bits, 2 stop bits, 5'b10011; tx_done on cycle 17.
  task automatic test_5n2;
    logic [0:0] exp_q[$];
    int n;
    exp_q = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    n = exp_q.size() * 2;
    sel = 3;
    @(negedge clk); send_v = 1'b1; data_v = 9'h013;
    for (int c = 1; c <= n + 2; c++) begin
      @(negedge clk);
      if (c == 1) send_v = 1'b0;
      checks++;
      if (c <= n) begin
        if (obs_tx !== exp_q[(c-1)/2] || obs_busy !== 1'b1 || obs_done !== 1'b0) begin
          failures++;
          $display("FAIL 5n2 cycle %0d: tx=%b busy=%b done=%b, required tx=%b busy=1 done=0",
                   c, obs_tx, obs_busy, obs_done, exp_q[(c-1)/2]);
        end
      end else if (obs_tx !== 1'b1 || obs_busy !== 1'b0 || obs_done !== (c == n + 1)) begin
        failures++;
        $display("FAIL 5n2 end cycle %0d: tx=%b busy=%b done=%b, required tx=1 busy=0 done=%b",
                 c, obs_tx, obs_busy, obs_done, (c == n + 1));
      end
    end
  endtask

  // send held high: 0x01 then 0x80 back to back, one tx_done each.
  task automatic test_back_to_back;
    logic [0:0] exp_q[$];
    logic exp_tx, exp_busy, exp_done;
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    sel = 0;
    @(negedge clk); send_v = 1'b1; data_v = 9'h001;
    for (int c = 1; c <= 43; c++) begin
      @(negedge clk);
      if (c == 1) data_v = 9'h080;
      if (c == 21 || c == 42 || c == 43) begin
        exp_tx = 1'b1; exp_busy = 1'b0; exp_done = (c != 43);
      end else begin
        exp_tx   = (c < 21) ? exp_q[(c-1)/2] : exp_q[10 + (c-22)/2];
        exp_busy = 1'b1; exp_done = 1'b0;
      end
      if (c == 42) send_v = 1'b0;
      checks++;
      if (obs_tx !== exp_tx || obs_busy !== exp_busy || obs_done !== exp_done) begin
        failures++;
        $display("FAIL b2b cycle %0d: tx=%b busy=%b done=%b, required tx=%b busy=%b done=%b",
                 c, obs_tx, obs_busy, obs_done, exp_tx, exp_busy, exp_done);
      end
    end
  endtask

  // A one-cycle send pulse mid-frame must neither disturb nor queue.
  task automatic test_ignore_send;
    logic [0:0] exp_q[$];
    int n;
    exp_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    n = exp_q.size() * 2;
    sel = 0;
    @(negedge clk); send_v = 1'b1; data_v = 9'h00F;
    for (int c = 1; c <= n + 4; c++) begin
      @(negedge clk);
      if (c == 1) send_v = 1'b0;
      if (c == 6) begin send_v = 1'b1; data_v = 9'h000; end
      if (c == 7) send_v = 1'b0;
      checks++;
      if (c <= n) begin
        if (obs_tx !== exp_q[(c-1)/2] || obs_busy !== 1'b1) begin
          failures++;
          $display("FAIL ignore cycle %0d: tx=%b busy=%b, required tx=%b busy=1",
                   c, obs_tx, obs_busy, exp_q[(c-1)/2]);
        end
      end else if (obs_tx !== 1'b1 || obs_busy !== 1'b0 || obs_done !== (c == n + 1)) begin
        failures++;
        $display("FAIL ignore end cycle %0d: tx=%b busy=%b done=%b, required tx=1 busy=0 done=%b",
                 c, obs_tx, obs_busy, obs_done, (c == n + 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_reset_mid_frame();
    test_reset_priority();
    test_parity();
    test_5n2();
    test_back_to_back();
    test_ignore_send();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
